// File: rtl/cic_interp3.sv
// Third-order CIC interpolator (N = 3, M = 1) for the audio playback path.
// Takes 8-bit signed base-rate samples through a one-deep buffer and emits
// R zero-stuffed, integrated output samples per input, one per tick_in.
// Comb and integrator arithmetic is W-bit two's complement and is allowed to
// wrap: the final truncation to OW bits is exact for every in-range input.
//
// Handshake: ready_in and tick_in are one-cycle strobes with no backpressure.
// ready_in means "x_in holds a new sample this cycle". tick_in means "the
// downstream takes one output". Each tick produces exactly one valid_out
// strobe two cycles later. need_out is high while the input buffer is empty.
module cic_interp3 #(
  parameter int R = 8,
  localparam int LR = $clog2(R),
  localparam int W = 8 + 3 * LR,
  localparam int OW = 8 + 2 * LR
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          ready_in,
  input  logic [7:0]    x_in,
  input  logic          tick_in,
  output logic [OW-1:0] y_out,
  output logic          valid_out,
  output logic          need_out,
  output logic          underflow_out,
  output logic          overflow_out
);

  logic [LR-1:0] phase;
  logic          full;
  logic [7:0]    buf_r;
  logic [7:0]    last_r;
  logic [7:0]    s8;
  logic          phase0_tick;
  logic          uf_now;
  logic          store_x;

  logic [W-1:0]  s_w;
  logic [W-1:0]  c1, c2, c3;
  logic [W-1:0]  d1, d2, d3;
  logic [W-1:0]  c_reg;
  logic          tick_d;
  logic [W-1:0]  i1, i2, i3;
  logic [W-1:0]  i1n, i2n, i3n;

  assign phase0_tick = tick_in && (phase == '0);
  assign need_out    = ~full;

  // Comb input select: buffered sample, else same-cycle bypass, else repeat last.
  always_comb begin
    s8     = last_r;
    uf_now = 1'b0;
    if (full) begin
      s8 = buf_r;
    end else if (ready_in) begin
      s8 = x_in;
    end else begin
      s8     = last_r;
      uf_now = phase0_tick;
    end
  end

  // A bypassed sample (consumed in the cycle it arrives) is not also buffered.
  assign store_x = ready_in && !(phase0_tick && !full);

  // Input buffer, last-consumed sample and the error pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      full          <= 1'b0;
      buf_r         <= '0;
      last_r        <= '0;
      underflow_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      underflow_out <= uf_now;
      overflow_out  <= ready_in && full && !phase0_tick;
      if (phase0_tick) begin
        last_r <= s8;
      end
      if (store_x) begin
        buf_r <= x_in;
        full  <= 1'b1;
      end else if (phase0_tick) begin
        full <= 1'b0;
      end
    end
  end

  // Phase counter: counts ticks only, wraps naturally at R.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase <= '0;
    end else if (tick_in) begin
      phase <= phase + 1'b1;
    end
  end

  // Three cascaded combs, differential delay 1, evaluated at base rate.
  always_comb begin
    s_w = {{(W-8){s8[7]}}, s8};
    c1  = s_w - d1;
    c2  = c1 - d2;
    c3  = c2 - d3;
  end

  // Comb delay registers advance only when a base-rate sample is consumed.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (phase0_tick) begin
      d1 <= s_w;
      d2 <= c1;
      d3 <= c2;
    end
  end

  // Zero-stuffing: comb output on phase 0, zero on every other tick.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      c_reg  <= '0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick_in;
      if (tick_in) begin
        c_reg <= phase0_tick ? c3 : '0;
      end
    end
  end

  // Integrator chain sums, each stage feeding the next in the same cycle.
  always_comb begin
    i1n = i1 + c_reg;
    i2n = i2 + i1n;
    i3n = i3 + i2n;
  end

  // Integrators and output register, enabled the cycle after each tick.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= tick_d;
      if (tick_d) begin
        i1    <= i1n;
        i2    <= i2n;
        i3    <= i3n;
        y_out <= i3n[OW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cic_interp3.sv
// Bench for cic_interp3: an R=8 and an R=4 instance share one stimulus
// stream. The reference model tracks the consumed base-rate samples and
// forms each output as a convolution with the CIC impulse response (the
// triple self-convolution of a length-R boxcar), independent of the
// comb/integrator structure.
module tb_cic_interp3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [7:0]  xin = '0;
  logic        tick = 1'b0;

  logic [13:0] y8;
  logic        v8, n8, u8, o8;
  logic [11:0] y4;
  logic        v4, n4, u4, o4;

  cic_interp3 #(.R(8)) dut8 (
    .clk_in(clk), .rst_in(rst_n), .ready_in(rdy), .x_in(xin), .tick_in(tick),
    .y_out(y8), .valid_out(v8), .need_out(n8), .underflow_out(u8), .overflow_out(o8)
  );

  cic_interp3 #(.R(4)) dut4 (
    .clk_in(clk), .rst_in(rst_n), .ready_in(rdy), .x_in(xin), .tick_in(tick),
    .y_out(y4), .valid_out(v4), .need_out(n4), .underflow_out(u4), .overflow_out(o4)
  );

  // clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // reference model state, index 0 = R8, 1 = R4
  int     rr[2] = '{8, 4};
  int     oww[2] = '{14, 12};
  longint h[2][0:45];
  int     sh[2][0:4095];
  int     nk[2];
  int     ntick[2];
  logic   m_full[2];
  int     m_buf[2];
  int     m_last[2];
  logic   pv[2];
  longint py[2];
  longint yh[2];
  logic   ev[2];
  logic   euf[2];
  logic   eof[2];

  longint cap8[$];
  longint cap4[$];
  int uf8_cnt = 0;
  int of8_cnt = 0;
  int v8_cnt = 0;

  function automatic longint wrap(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      nk[d] = 0; ntick[d] = 0; m_full[d] = 1'b0; m_buf[d] = 0; m_last[d] = 0;
      pv[d] = 1'b0; py[d] = 0; yh[d] = 0; ev[d] = 1'b0; euf[d] = 1'b0; eof[d] = 1'b0;
    end
  endtask

  // One clock of the reference model for instance d, given this cycle's inputs.
  task automatic model_cycle(input int d, input logic r, input logic [7:0] x, input logic t);
    int s;
    logic cons;
    longint acc;
    int j;
    ev[d] = pv[d];
    if (pv[d]) yh[d] = py[d];
    euf[d] = 1'b0;
    eof[d] = 1'b0;
    cons = 1'b0;
    if (t) begin
      cons = (ntick[d] % rr[d]) == 0;
      if (cons) begin
        if (m_full[d]) s = m_buf[d];
        else if (r) s = int'($signed(x));
        else begin s = m_last[d]; euf[d] = 1'b1; end
        m_last[d] = s;
        sh[d][nk[d]] = s;
        nk[d]++;
      end
      acc = 0;
      for (int k = nk[d] - 1; k >= 0; k--) begin
        j = ntick[d] - k * rr[d];
        if (j > 3 * rr[d] - 3) break;
        acc += longint'(sh[d][k]) * h[d][j];
      end
      py[d] = wrap(acc, oww[d]);
      pv[d] = 1'b1;
      ntick[d]++;
    end else begin
      pv[d] = 1'b0;
    end
    if (r) begin
      if (!(cons && !m_full[d])) begin
        if (!cons && m_full[d]) eof[d] = 1'b1;
        m_buf[d] = int'($signed(x));
        m_full[d] = 1'b1;
      end
    end else if (cons) begin
      m_full[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    check("y8", longint'($signed(y8)), yh[0]);
    check("valid8", longint'(v8), longint'(ev[0]));
    check("need8", longint'(n8), longint'(!m_full[0]));
    check("underflow8", longint'(u8), longint'(euf[0]));
    check("overflow8", longint'(o8), longint'(eof[0]));
    check("y4", longint'($signed(y4)), yh[1]);
    check("valid4", longint'(v4), longint'(ev[1]));
    check("need4", longint'(n4), longint'(!m_full[1]));
    check("underflow4", longint'(u4), longint'(euf[1]));
    check("overflow4", longint'(o4), longint'(eof[1]));
    if (v8) begin cap8.push_back(longint'($signed(y8))); v8_cnt++; end
    if (v4) cap4.push_back(longint'($signed(y4)));
    if (u8) uf8_cnt++;
    if (o8) of8_cnt++;
  endtask

  // driver: apply inputs for one cycle, advance model, sample #1 after the edge
  task automatic step(input logic r, input logic [7:0] x, input logic t);
    rdy = r; xin = x; tick = t;
    @(posedge clk);
    model_cycle(0, r, x, t);
    model_cycle(1, r, x, t);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  // one base period: sample first, then rr ticks with random spacing
  task automatic feed(input int rr_n, input logic [7:0] xv, input int maxgap);
    step(1'b1, xv, 1'b0);
    for (int i = 0; i < rr_n; i++) begin
      step(1'b0, 8'($urandom), 1'b1);
      idle($urandom_range(0, maxgap));
    end
  endtask

  // one base period of continuous ticks, sample bypassed on the phase-0 tick
  task automatic feed_bypass(input int rr_n, input logic [7:0] xv);
    step(1'b1, xv, 1'b1);
    for (int i = 1; i < rr_n; i++) step(1'b0, 8'($urandom), 1'b1);
  endtask

  task automatic ticks_only(input int rr_n);
    for (int i = 0; i < rr_n; i++) step(1'b0, 8'($urandom), 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("rst_y8", longint'(y8), 0);
    check("rst_valid8", longint'(v8), 0);
    check("rst_need8", longint'(n8), 1);
    check("rst_uf8", longint'(u8), 0);
    check("rst_of8", longint'(o8), 0);
    check("rst_y4", longint'(y4), 0);
    check("rst_valid4", longint'(v4), 0);
    check("rst_need4", longint'(n4), 1);
    check("rst_uf4", longint'(u4), 0);
    check("rst_of4", longint'(o4), 0);
  endtask

  // asynchronous reset dropped between edges, then released
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic run_impulse8();
    cap8 = {};
    feed(8, 8'd1, 2);
    for (int i = 0; i < 3; i++) feed(8, 8'd0, 2);
    idle(2);
  endtask

  task automatic check_impulse8(input string tag);
    int exp8[23] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48,
                     46, 42, 36, 28, 21, 15, 10, 6, 3, 1, 0};
    check({tag, "_len"}, longint'(cap8.size() >= 23), 1);
    for (int i = 0; i < 23; i++)
      if (i < cap8.size()) check($sformatf("%s[%0d]", tag, i), cap8[i], longint'(exp8[i]));
  endtask

  initial begin
    int uf0, of0, vc0;
    int exp4[11] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};

    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j <= 45; j++) h[d][j] = 0;
      for (int a = 0; a < rr[d]; a++)
        for (int b = 0; b < rr[d]; b++)
          for (int c = 0; c < rr[d]; c++)
            h[d][a + b + c]++;
    end
    model_reset();

    // power-up reset
    #12 check_reset_outputs();
    #4 rst_n = 1'b1;
    idle(2);

    // impulse, R=8
    run_impulse8();
    check_impulse8("imp8");

    // DC levels, R=8
    for (int i = 0; i < 4; i++) feed(8, 8'd100, 1);
    idle(2);
    check("dc_100", longint'($signed(y8)), 6400);
    for (int i = 0; i < 4; i++) feed(8, 8'h80, 1);
    idle(2);
    check("dc_m128", longint'($signed(y8)), -8192);
    for (int i = 0; i < 4; i++) feed(8, 8'd127, 1);
    idle(2);
    check("dc_127", longint'($signed(y8)), 8128);

    // back-to-back ticks with bypassed samples
    uf0 = uf8_cnt; vc0 = v8_cnt;
    for (int i = 0; i < 6; i++) feed_bypass(8, 8'($urandom));
    idle(2);
    check("b2b_valid_count", longint'(v8_cnt - vc0), 48);
    check("b2b_no_underflow", longint'(uf8_cnt - uf0), 0);

    // underflow: withhold one sample during a DC run, level is held
    for (int i = 0; i < 4; i++) feed(8, 8'd50, 1);
    uf0 = uf8_cnt;
    ticks_only(8);
    idle(2);
    check("uf_count", longint'(uf8_cnt - uf0), 1);
    check("uf_dc_hold", longint'($signed(y8)), 3200);

    // overflow: two samples before the phase-0 tick, second one wins
    of0 = of8_cnt;
    step(1'b1, 8'd5, 1'b0);
    step(1'b1, 8'd30, 1'b0);
    ticks_only(8);
    for (int i = 0; i < 3; i++) feed(8, 8'd30, 1);
    idle(2);
    check("of_count", longint'(of8_cnt - of0), 1);
    check("of_dc", longint'($signed(y8)), 1920);

    // random traffic, including simultaneous ready/tick events
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 5) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
    idle(2);

    // reset mid-stream during a DC run, then impulse again
    for (int i = 0; i < 2; i++) feed(8, 8'd100, 1);
    step(1'b1, 8'd100, 1'b0);
    ticks_only(3);
    reset_mid();
    run_impulse8();
    check_impulse8("imp8_after_rst");

    // phase wrap, R=4 impulse
    reset_mid();
    cap4 = {};
    feed(4, 8'd1, 2);
    for (int i = 0; i < 4; i++) feed(4, 8'd0, 2);
    idle(2);
    check("imp4_len", longint'(cap4.size() >= 11), 1);
    for (int i = 0; i < 11; i++)
      if (i < cap4.size()) check($sformatf("imp4[%0d]", i), cap4[i], longint'(exp4[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cic_interp3.md
# cic_interp3

Third-order CIC interpolator for the audio playback path. It accepts 8-bit signed samples at the base sample rate and emits R output samples per input sample, one per downstream output tick, for the DAC/PWM stage. It is the transmit-direction counterpart of the capture-path low-pass FIR, which band-limits and consumes samples at the base rate. It contains a one-deep input buffer with underflow and overflow reporting, so upstream and downstream rates only need to be nominally locked.

## Interface
- R, default 8: interpolation ratio. Legal values are 2, 4, 8 and 16. Derived widths:
  - LR = log2(R)
  - W = 8 + 3·LR, the internal width
  - OW = 8 + 2·LR, the output width
- Order N = 3 and differential delay M = 1 are fixed.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- ready_in  input  1  one-cycle strobe: x_in holds a new base-rate sample.
- x_in  input  8  signed input sample.
- tick_in  input  1  one-cycle strobe: downstream requests one output sample. Back-to-back ticks are legal.
- y_out  output  OW  signed output sample. Held between updates.
- valid_out  output  1  one-cycle strobe: y_out just updated.
- need_out  output  1  high while the input buffer is empty.
- underflow_out  output  1  one-cycle pulse: a phase-0 tick found no new sample.
- overflow_out  output  1  one-cycle pulse: a buffered sample was overwritten before use.

## Operation
- **Input buffer:** register buf plus flag full.
  - ready_in stores x_in and sets full.
  - A phase-0 tick consumes buf and clears full.
- **Phase counter:** phase, LR bits, wraps R-1 to 0.
  - Increments on every tick_in, and on no other event.
- **Comb section:** three cascaded combs at base rate, M = 1.
  - The W-bit delay registers update only on phase-0 ticks.
  - The comb input s is selected as follows:
    - buf if full;
    - else x_in if ready_in is high in the same cycle (bypass; x_in is then not also buffered);
    - else last, with underflow_out pulsed.
  - last is the most recently consumed sample; it is updated to s on every phase-0 tick.
- **Simultaneous events:**
  - Phase-0 tick with full set and ready_in high: buf is consumed, x_in is stored, full stays set, no overflow.
  - ready_in with full set and no consuming tick: buf is overwritten and overflow_out pulses.
- **Zero-stuffing:** the comb output is registered into c_reg on every tick.
  - Phase-0 tick: c_reg takes the comb output.
  - Any other phase: c_reg takes 0.
- **Integrators:** three W-bit integrators, enabled the cycle after each tick.
  - i1n = i1 + c_reg; i2n = i2 + i1n; i3n = i3 + i2n.
  - i1, i2 and i3 are registered to i1n, i2n and i3n.
  - y_out is registered to i3n[OW-1:0].
- **Arithmetic:** all comb and integrator arithmetic is W-bit two's complement and wraps with no saturation. Wrap is required for correctness.
  - DC gain is R².
  - OW holds every in-range result exactly: -128·R² through 127·R².
- **Reset (rst_in low), asynchronous:**
  - Zero: y_out, valid_out, underflow_out, overflow_out, phase, full, buf, last, and all comb, c_reg and integrator registers.
  - need_out = 1.
  - Reset mid-stream discards all state. The first phase-0 tick after release behaves as if at power-up.

## Timing
- Tick sampled at edge e, where the tick is high in cycle t:
  - comb registers, c_reg and phase update at e;
  - integrators and y_out update at e+1;
  - valid_out is high during cycle t+2.
- Fixed latency is 2 cycles, independent of R and of tick spacing.
- underflow_out is high during cycle t+1 for an underflowing phase-0 tick in cycle t.
- overflow_out is high during cycle t+1 for an overwriting ready_in in cycle t.
- need_out is combinational from full: it drops in the cycle after ready_in and rises in the cycle after the consuming tick.
- Throughput is one output per tick, with ticks allowed every cycle.
- The upstream must supply one ready_in per R ticks, anywhere within the phase window.

## Test plan
- **Impulse, R=8:** x = 1 once, then zeros, each sample ahead of its phase-0 tick. The first 22 valid_out values must be 1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1, followed by 0.
- **DC, R=8:**
  - Constant x = 100: y_out settles to 6400 by output 22 and stays there.
  - x = -128 gives -8192; x = 127 gives 8128. Confirms wrap-correct width.
- **Latency and back-to-back ticks:** continuous tick_in every cycle with ready_in bypassed on each phase-0 cycle. valid_out must be high every cycle starting 2 cycles after the first tick, and there must be no underflow.
- **Underflow and overflow:**
  - Withhold ready_in for one base period: underflow_out pulses once, and the output continues with last repeated (the DC value is held).
  - Two ready_in before the next phase-0 tick: overflow_out pulses, and the second sample is the one used.
- **Reset mid-stream:** drop rst_in asynchronously between clock edges during a DC run.
  - All outputs must be 0 immediately, with need_out = 1.
  - After release, the impulse scenario must reproduce exactly.
- **Phase wrap, R=4:** the impulse response must be 1, 3, 6, 10, 12, 12, 10, 6, 3, 1 (sum 64), with phase wrapping every 4 ticks.
